// File: rtl/char_map_buffer_pkg.sv
// Shared geometry, address width and controller state encoding for the
// 80x30 text-mode character map buffer.
package char_map_buffer_pkg;

  localparam int         COLS   = 80;
  localparam int         ROWS   = 30;
  localparam logic [7:0] BLANK  = 8'h20;
  localparam int         ADDR_W = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // row*80 as two shifted copies so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] row_times_80(input logic [4:0] row);
    logic [ADDR_W-1:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/char_map_buffer_ram.sv
// Simple dual-port character storage: one synchronous write port, one
// synchronous read port, no reset, so it maps onto a block RAM.
module char_ram
  import char_map_buffer_pkg::*;
#(
  parameter int DEPTH = COLS * ROWS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; a reset term would stop it
  // mapping to block RAM. Both ports use <= in one block, so a same-address
  // read in the write cycle returns the old contents (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_map_buffer.sv
// Text-mode character map: CPU-side write port with range check, a
// full-screen clear sweep (also run after every reset) and a display read port.
module char_map_buffer
  import char_map_buffer_pkg::ADDR_W;
  import char_map_buffer_pkg::state_t;
  import char_map_buffer_pkg::IDLE;
  import char_map_buffer_pkg::CLEAR;
  import char_map_buffer_pkg::row_times_80;
#(
  parameter int         COLS  = char_map_buffer_pkg::COLS,
  parameter int         ROWS  = char_map_buffer_pkg::ROWS,
  parameter logic [7:0] BLANK = char_map_buffer_pkg::BLANK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [7:0] wr_char,
  output logic       wr_drop,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_char
);

  localparam int                CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [6:0] col,
                                                 input logic [4:0] row);
    logic [ADDR_W-1:0] base;
    if (COLS == 80) base = row_times_80(row);
    else            base = {7'd0, row} * ADDR_W'(COLS);
    return base + ADDR_W'(col);
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              rd_oob_q;
  logic              wr_fire;
  logic              wr_oob;
  logic              rd_oob;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_q;

  assign wr_oob   = (int'(wr_col) >= COLS) || (int'(wr_row) >= ROWS);
  assign rd_oob   = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);

  // A pending clear request blocks the write in the same cycle.
  assign wr_ready = (state == IDLE) && !clr_req;
  assign wr_fire  = wr_valid && wr_ready;
  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == CLEAR) && (sweep_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      wr_drop   <= 1'b0;
      rd_oob_q  <= 1'b1;
    end else begin
      wr_drop  <= wr_fire && wr_oob;
      rd_oob_q <= rd_oob;
      case (state)
        IDLE: begin
          if (clr_req) state <= CLEAR;
        end
        CLEAR: begin
          if (sweep_cnt == LAST) begin
            sweep_cnt <= '0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign ram_we    = clr_busy || (wr_fire && !wr_oob);
  assign ram_waddr = clr_busy ? sweep_cnt : lin_addr(wr_col, wr_row);
  assign ram_wdata = clr_busy ? BLANK : wr_char;
  // Out-of-range reads are steered to a legal address and masked on output.
  assign ram_raddr = rd_oob ? '0 : lin_addr(rd_col, rd_row);

  char_ram #(
    .DEPTH (CELLS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  assign rd_char = rd_oob_q ? BLANK : ram_q;

endmodule

// File: tb/tb_char_map_buffer.sv
// Randomised scoreboard bench for char_map_buffer against a cell-array
// reference model of the character map.
module tb_char_map_buffer;
  import char_map_buffer_pkg::*;

  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_col = '0;
  logic [4:0] wr_row = '0;
  logic [7:0] wr_char = '0;
  logic       wr_drop;
  logic       clr_req = 1'b0;
  logic       clr_busy;
  logic       clr_done;
  logic [6:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [7:0] rd_char;

  char_map_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_col   (wr_col),
    .wr_row   (wr_row),
    .wr_char  (wr_char),
    .wr_drop  (wr_drop),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .rd_col   (rd_col),
    .rd_row   (rd_row),
    .rd_char  (rd_char)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    bit         ready;
    bit         busy;
    bit         drop;
    bit         done;
    bit         rd_chk;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, req);
    end
  endtask

  // Monitor: one expectation per clock, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_ready", 8'(wr_ready), 8'(e.ready));
      check("clr_busy", 8'(clr_busy), 8'(e.busy));
      check("clr_done", 8'(clr_done), 8'(e.done));
      check("wr_drop",  8'(wr_drop),  8'(e.drop));
      if (e.rd_chk) check("rd_char", rd_char, e.rd);
    end
  end

  // Reference model: the screen as a flat cell array plus clear progress.
  logic [7:0] m_mem   [CELLS];
  bit         m_known [CELLS];
  bit         m_clear  = 1'b1;
  int         m_pos    = 0;
  bit         m_drop   = 1'b0;
  bit         m_rd_chk = 1'b1;
  logic [7:0] m_rd     = BLANK;

  task automatic reset_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      wr_valid = $urandom_range(0, 1);
      clr_req  = $urandom_range(0, 1);
      e.ready = 0; e.busy = 1; e.drop = 0; e.done = 0; e.rd_chk = 1; e.rd = BLANK;
      exp_q.push_back(e);
      m_clear = 1; m_pos = 0; m_drop = 0; m_rd_chk = 1; m_rd = BLANK;
      @(posedge clk); #1;
    end
  endtask

  task automatic step(input bit wv, input int col, input int row, input logic [7:0] ch,
                      input bit clr, input int rcol, input int rrow);
    exp_t e;
    rst = 1'b1;
    wr_valid = wv; wr_col = 7'(col); wr_row = 5'(row); wr_char = ch;
    clr_req = clr; rd_col = 7'(rcol); rd_row = 5'(rrow);
    e.ready  = !m_clear && !clr;
    e.busy   = m_clear;
    e.done   = m_clear && (m_pos == CELLS - 1);
    e.drop   = m_drop;
    e.rd_chk = m_rd_chk;
    e.rd     = m_rd;
    exp_q.push_back(e);
    if (rcol >= COLS || rrow >= ROWS) begin
      m_rd_chk = 1; m_rd = BLANK;
    end else begin
      m_rd_chk = m_known[rrow * COLS + rcol];
      m_rd     = m_mem[rrow * COLS + rcol];
    end
    m_drop = 0;
    if (m_clear) begin
      m_mem[m_pos] = BLANK; m_known[m_pos] = 1;
      m_pos++;
      if (m_pos == CELLS) begin m_clear = 0; m_pos = 0; end
    end else if (clr) begin
      m_clear = 1;
    end else if (wv) begin
      if (col >= COLS || row >= ROWS) m_drop = 1;
      else begin
        m_mem[row * COLS + col] = ch; m_known[row * COLS + col] = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic int rnd_col();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(COLS, 127)) : int'($urandom_range(0, COLS - 1));
  endfunction

  function automatic int rnd_row();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(ROWS, 31)) : int'($urandom_range(0, ROWS - 1));
  endfunction

  task automatic random_step(input int wr_pct, input int clr_div);
    step($urandom_range(0, 99) < wr_pct, rnd_col(), rnd_row(), 8'($urandom),
         $urandom_range(0, clr_div - 1) == 0, rnd_col(), rnd_row());
  endtask

  // Sweep with writes and clear requests hammering; the model ignores both.
  task automatic run_sweep();
    for (int i = 0; i < CELLS + 16 && m_clear; i++)
      step(1, rnd_col(), rnd_row(), 8'($urandom), $urandom_range(0, 1), rnd_col(), rnd_row());
  endtask

  initial begin
    @(posedge clk); #1;
    reset_cycles(3);
    run_sweep();
    for (int i = 0; i < 64; i++) step(0, 0, 0, 8'h00, 0, rnd_col(), rnd_row());

    step(1, 35, 9, 8'h52, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 35, 9);
    step(0, 0, 0, 8'h00, 0, 0, 0);

    step(1, 80, 0, 8'hAA, 0, 79, 0);
    step(1, 0, 30, 8'hBB, 0, 0, 29);
    step(0, 0, 0, 8'h00, 0, 79, 0);
    step(0, 0, 0, 8'h00, 0, 0, 29);
    step(0, 0, 0, 8'h00, 0, 127, 31);

    step(1, 5, 5, 8'h41, 0, 5, 5);
    step(0, 0, 0, 8'h00, 0, 5, 5);
    step(0, 0, 0, 8'h00, 0, 0, 0);

    step(1, 10, 3, 8'h77, 1, 10, 3);
    run_sweep();
    step(0, 0, 0, 8'h00, 0, 10, 3);
    step(0, 0, 0, 8'h00, 0, 35, 9);

    for (int i = 0; i < 200; i++) random_step(70, 1000);
    step(0, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < CELLS && m_clear && m_pos < 1000; i++)
      step(0, 0, 0, 8'h00, 0, rnd_col(), rnd_row());
    reset_cycles(2);
    run_sweep();

    for (int i = 0; i < 1500; i++) random_step(60, 400);
    run_sweep();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h00, 0, rnd_col(), rnd_row());

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
